// File: rtl/amp_ctrl_pkg.sv
// Shared types and helpers for the amp_frame_scaler block.
package amp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LATCH = 3'd2,
        PROC  = 3'd3,
        WR    = 3'd4,
        WAIT  = 3'd5
    } state_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic longint sat_hi(input int w);
        return (longint'(1) << (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/amp_frame_scaler_if.sv
// FIFO-side handshake bundle of amp_frame_scaler; master is the scaler itself.
interface amp_frame_scaler_if #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16
);
    logic [GAIN_W-1:0] gain;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_rden;
    logic              fifo_almost_full;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_wren;
    logic              busy;
    logic              frame_done;
    logic              sat_pulse;

    modport master (
        input  gain, fifo_empty, fifo_rdata, fifo_almost_full,
        output fifo_rden, fifo_wdata, fifo_wren, busy, frame_done, sat_pulse
    );

    modport slave (
        output gain, fifo_empty, fifo_rdata, fifo_almost_full,
        input  fifo_rden, fifo_wdata, fifo_wren, busy, frame_done, sat_pulse
    );
endinterface

// File: rtl/amp_mult_sat.sv
// Combinational signed x unsigned fixed-point multiply, floor shift, then clamp or wrap.
// Clamping and the sat flag exist only when AMP_SAT_EN is defined.
module amp_mult_sat
    import amp_ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 12
) (
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic        [GAIN_W-1:0] i_gain,
    output logic signed [DATA_W-1:0] o_result,
    output logic                     o_sat
);
    localparam int PW = DATA_W + GAIN_W + 1;

    logic signed [PW-1:0] w_samp_ext;
    logic signed [PW-1:0] w_gain_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;

    assign w_samp_ext = {{(PW-DATA_W){i_sample[DATA_W-1]}}, i_sample};
    assign w_gain_ext = {{(PW-GAIN_W){1'b0}}, i_gain};
    assign w_prod     = w_samp_ext * w_gain_ext;
    // arithmetic shift floors toward minus infinity
    assign w_shift    = w_prod >>> GAIN_FRAC;

`ifdef AMP_SAT_EN
    localparam logic signed [PW-1:0] SAT_HI = PW'(sat_hi(DATA_W));
    localparam logic signed [PW-1:0] SAT_LO = PW'(sat_lo(DATA_W));

    always_comb begin
        o_result = DATA_W'(w_shift);
        o_sat    = 1'b0;
        if (w_shift > SAT_HI) begin
            o_result = DATA_W'(SAT_HI);
            o_sat    = 1'b1;
        end else if (w_shift < SAT_LO) begin
            o_result = DATA_W'(SAT_LO);
            o_sat    = 1'b1;
        end
    end
`else
    assign o_result = DATA_W'(w_shift);
    assign o_sat    = 1'b0;
`endif
endmodule

// File: rtl/amp_frame_scaler.sv
// Frame-based amplitude scaler between an input and an output sample FIFO.
// Optional clamping of scaled words via AMP_SAT_EN (wraps when undefined).
//   state | meaning
//   IDLE  | waiting for go, samples gain at frame start
//   RD    | read strobe to input FIFO
//   LATCH | capture returned word
//   PROC  | register scaled result
//   WR    | write strobe to output FIFO
//   WAIT  | mid-frame stall until go
module amp_frame_scaler
    import amp_ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 12,
    parameter int FRAME_LEN = 6,
    parameter int PROC_LEN  = 3
) (
    input logic clk,
    input logic reset,
    amp_frame_scaler_if.master bus
);
    localparam int IW = idx_width(FRAME_LEN);

    state_t                    r_state, w_nxt;
    logic [IW-1:0]             r_idx;
    logic [GAIN_W-1:0]         r_gain;
    logic signed [DATA_W-1:0]  r_sample;
    logic signed [DATA_W-1:0]  r_result;
    logic signed [DATA_W-1:0]  w_result;
    logic                      w_sat, w_go, w_is_proc, w_last;
    logic                      r_rden, r_wren, r_busy, r_done, r_sat;
    logic [DATA_W-1:0]         r_wdata;

    amp_mult_sat #(
        .DATA_W    (DATA_W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_mult (
        .i_sample (r_sample),
        .i_gain   (r_gain),
        .o_result (w_result),
        .o_sat    (w_sat)
    );

    assign w_go      = !bus.fifo_empty && !bus.fifo_almost_full;
    assign w_is_proc = int'(r_idx) < PROC_LEN;
    assign w_last    = int'(r_idx) == FRAME_LEN - 1;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_go) w_nxt = RD;
            RD:      w_nxt = LATCH;
            LATCH:   w_nxt = w_is_proc ? PROC : WR;
            PROC:    w_nxt = WR;
            WR:      w_nxt = w_last ? IDLE : (w_go ? RD : WAIT);
            WAIT:    if (w_go) w_nxt = RD;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_gain   <= '0;
            r_sample <= '0;
            r_result <= '0;
            r_rden   <= 1'b0;
            r_wren   <= 1'b0;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                IDLE:    if (w_go) begin
                             r_gain <= bus.gain;
                             r_idx  <= '0;
                         end
                LATCH:   r_sample <= bus.fifo_rdata;
                PROC:    r_result <= w_result;
                WR:      if (!w_last) r_idx <= r_idx + IW'(1);
                default: ;
            endcase
            // outputs are registered from the next state so they line up with it
            r_rden <= (w_nxt == RD);
            r_wren <= (w_nxt == WR);
            r_busy <= (w_nxt != IDLE);
            r_done <= (w_nxt == WR) && w_last;
            r_sat  <= (r_state == PROC) && w_sat;
            if (w_nxt == WR)
                r_wdata <= (r_state == PROC) ? w_result : bus.fifo_rdata;
        end
    end

    assign bus.fifo_rden  = r_rden;
    assign bus.fifo_wren  = r_wren;
    assign bus.fifo_wdata = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
    assign bus.sat_pulse  = r_sat;
endmodule

// File: tb/tb_amp_frame_scaler.sv
// Self-checking bench for amp_frame_scaler; reference model honours AMP_SAT_EN.
module tb_amp_frame_scaler;
    localparam int FL = 6;
    localparam int PL = 3;

    typedef logic [15:0] frame_t [FL];
    typedef struct { logic [15:0] d; logic s; logic dn; int cyc; } wr_t;
    typedef struct { logic [15:0] d; logic s; logic dn; } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0, bad = 0;
    int   rd_total = 0, out_cnt = 0, viol = 0, underflow = 0;

    logic [15:0] fifo_q [$];
    logic [15:0] pend_q [$];
    wr_t         cap_q [$];
    exp_t        exp_q [$];

    amp_frame_scaler_if #(.DATA_W(16), .GAIN_W(16)) bus ();

    amp_frame_scaler #(
        .DATA_W(16), .GAIN_W(16), .GAIN_FRAC(12), .FRAME_LEN(FL), .PROC_LEN(PL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // input FIFO emulation and output capture, sampled away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            out_cnt = 0;
            bus.fifo_rdata = '0;
        end else begin
            if (bus.fifo_rden) begin
                rd_total++;
                out_cnt++;
                if (fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
                else underflow++;
            end
            if (bus.fifo_wren) begin
                out_cnt--;
                cap_q.push_back('{bus.fifo_wdata, bus.sat_pulse, bus.frame_done, cyc});
            end
            if (bus.fifo_rden && bus.fifo_wren) viol++;
            if (out_cnt > 1 || out_cnt < 0) viol++;
            if (!bus.fifo_wren && (bus.sat_pulse || bus.frame_done)) viol++;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_word(input logic [15:0] s, input logic [15:0] g, input bit proc,
                            output logic [15:0] y, output logic sat);
        longint p, q;
        sat = 1'b0;
        y   = s;
        if (proc) begin
            p = longint'($signed(s)) * longint'(g);
            q = (p >= 0) ? p / 4096 : -((-p + 4095) / 4096);
`ifdef AMP_SAT_EN
            if (q > 32767) begin y = 16'h7FFF; sat = 1'b1; end
            else if (q < -32768) begin y = 16'h8000; sat = 1'b1; end
            else y = q[15:0];
`else
            y = q[15:0];
`endif
        end
    endtask

    // queue a frame's expectations; only the first k words go into the FIFO now
    task automatic push_frame(input logic [15:0] g, input frame_t w, input int k);
        logic [15:0] y;
        logic        s;
        for (int i = 0; i < FL; i++) begin
            ref_word(w[i], g, i < PL, y, s);
            exp_q.push_back('{y, s, i == FL - 1});
            if (i < k) fifo_q.push_back(w[i]);
            else pend_q.push_back(w[i]);
        end
    endtask

    task automatic rand_frame(output frame_t w);
        for (int i = 0; i < FL; i++) w[i] = 16'($urandom());
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        chk("write_count", cap_q.size(), n);
    endtask

    task automatic wait_reads(input int n, input int budget);
        int k = 0;
        while (rd_total < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        chk("read_count", rd_total, n);
    endtask

    task automatic check_frames(input int nf, input bit spacing);
        wr_t  c;
        exp_t e;
        int   prev = 0;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < FL; i++) begin
                if (cap_q.size() == 0 || exp_q.size() == 0) return;
                c = cap_q.pop_front();
                e = exp_q.pop_front();
                chk($sformatf("data_f%0d_w%0d", f, i), c.d, e.d);
                chk($sformatf("sat_f%0d_w%0d", f, i), c.s, e.s);
                chk($sformatf("done_f%0d_w%0d", f, i), c.dn, e.dn);
                if (spacing && (i > 0 || f > 0))
                    chk($sformatf("spacing_f%0d_w%0d", f, i), c.cyc - prev,
                        (i == 0 ? 1 : 0) + (i < PL ? 4 : 3));
                prev = c.cyc;
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rden"},  bus.fifo_rden, 0);
        chk({tag, "_wren"},  bus.fifo_wren, 0);
        chk({tag, "_wdata"}, bus.fifo_wdata, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_done"},  bus.frame_done, 0);
        chk({tag, "_sat"},   bus.sat_pulse, 0);
    endtask

    initial begin
        frame_t w;
        logic [15:0] g;
        int base;

        reset = 1'b1;
        bus.gain = '0;
        bus.fifo_almost_full = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // unity gain, two back-to-back frames
        bus.gain = 16'h1000;
        push_frame(16'h1000, '{16'h1234, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h4000}, FL);
        rand_frame(w);
        push_frame(16'h1000, w, FL);
        wait_writes(12, 200);
        check_frames(2, 1'b1);

        // gain 2.0, clipping at both rails
        bus.gain = 16'h2000;
        w = '{16'h7000, 16'h9000, 16'h0100, 16'hFFFF, 16'h8000, 16'h0001};
        push_frame(16'h2000, w, FL);
        wait_writes(6, 100);
        check_frames(1, 1'b1);

        // gain 0.5, floor of -0.5 and passthrough of -1
        bus.gain = 16'h0800;
        w = '{16'hFFFF, 16'h0003, 16'hFFFD, 16'hFFFF, 16'h1111, 16'h8000};
        push_frame(16'h0800, w, FL);
        wait_writes(6, 100);
        check_frames(1, 1'b1);

        // random gains and data
        for (int f = 0; f < 6; f++) begin
            g = 16'($urandom());
            bus.gain = g;
            rand_frame(w);
            push_frame(g, w, FL);
            wait_writes(6, 100);
            check_frames(1, 1'b1);
        end

        // input FIFO runs dry after two words; gain change during the stall is ignored
        bus.gain = 16'h1000;
        w = '{16'h0100, 16'h0200, 16'h1000, 16'h2000, 16'hF000, 16'h0300};
        push_frame(16'h1000, w, 2);
        wait_writes(2, 60);
        base = rd_total;
        bus.gain = 16'h3000;
        repeat (10) @(negedge clk);
        #1;
        chk("gap_rden", rd_total - base, 0);
        chk("gap_busy", bus.busy, 1);
        chk("gap_writes", cap_q.size(), 2);
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        wait_writes(6, 100);
        check_frames(1, 1'b0);

        // almost-full rises in the LATCH cycle of word 4
        g = 16'($urandom());
        bus.gain = g;
        rand_frame(w);
        base = rd_total;
        push_frame(g, w, FL);
        wait_reads(base + 5, 100);
        @(posedge clk);
        #1 bus.fifo_almost_full = 1'b1;
        wait_writes(5, 40);
        repeat (10) @(negedge clk);
        #1;
        chk("af_rden", rd_total - base, 5);
        chk("af_writes", cap_q.size(), 5);
        chk("af_busy", bus.busy, 1);
        bus.fifo_almost_full = 1'b0;
        wait_writes(6, 40);
        check_frames(1, 1'b0);

        // reset in the PROC cycle of word 2, then a fresh frame with a new gain
        bus.gain = 16'h2000;
        rand_frame(w);
        base = rd_total;
        push_frame(16'h2000, w, FL);
        wait_reads(base + 3, 100);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        fifo_q.delete();
        pend_q.delete();
        exp_q.delete();
        cap_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        g = 16'h0C00;
        bus.gain = g;
        w = '{16'h4000, 16'hC000, 16'h7FFF, 16'h1234, 16'h5678, 16'h9ABC};
        push_frame(g, w, FL);
        wait_writes(6, 100);
        check_frames(1, 1'b1);

        repeat (10) @(negedge clk);
        #1;
        chk("extra_writes", cap_q.size(), 0);
        chk("idle_busy", bus.busy, 0);
        chk("protocol_viol", viol, 0);
        chk("fifo_underflow", underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
